// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 hex keypad one column at a time, debounces presses and
//   releases, and presents each accepted key as a hex code for a RAT input
//   port. Each accepted key also raises a one-cycle interrupt pulse.
//
// Ports
//   CLK        system clock
//   RST        synchronous active-high reset
//   ROWS[3:0]  keypad rows, active-low, asynchronous to CLK
//   KEY_ACK    one-cycle pulse from the port-read decode; clears KEY_VALID/OVERRUN
//   COLS[3:0]  column drive, active-low, exactly one bit low
//   KEY_CODE   {4'h0, hex key} of the most recent accepted key
//   KEY_VALID  high from key accept until KEY_ACK
//   INTR       one-cycle pulse per accepted key
//   OVERRUN    sticky: a key was accepted while KEY_VALID was still high
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | rotating columns, looking for exactly one low row on a tick
// DEBOUNCE | column frozen, counting ticks that repeat the captured pattern
// HELD     | key accepted, column frozen, counting all-high ticks to release
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] ROWS,
   input  logic       KEY_ACK,
   output logic [3:0] COLS,
   output logic [7:0] KEY_CODE,
   output logic       KEY_VALID,
   output logic       INTR,
   output logic       OVERRUN
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       rows_meta_q, rows_meta_d;
   logic [3:0]       rows_s_q, rows_s_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       pat_q, pat_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             intr_q, intr_d;
   logic             overrun_q, overrun_d;

   logic             tick;
   logic             one_low;
   logic [1:0]       row_idx;
   logic             accept;
   logic [1:0]       accept_row;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Divider is a down-counter; the tick falls on the same cycle an up-count
   // from zero would reach SCAN_DIV-1.
   assign tick = (div_q == '0);

   // Only a single low row is a press; none or several are ignored.
   always_comb begin
      one_low = 1'b1;
      row_idx = 2'd0;
      case (rows_s_q)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rows_meta_d = ROWS;
      rows_s_d    = rows_meta_q;
      div_d       = tick ? DIV_LOAD : div_q - DIV_W'(1);
      col_d       = col_q;
      row_d       = row_q;
      pat_d       = pat_q;
      match_cnt_d = match_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      intr_d      = 1'b0;
      overrun_d   = overrun_q;
      accept      = 1'b0;
      accept_row  = row_q;

      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (one_low) begin
                  row_d = row_idx;
                  pat_d = rows_s_q;
                  if (DEBOUNCE_SCANS == 1) begin
                     accept     = 1'b1;
                     accept_row = row_idx;
                     rel_cnt_d  = '0;
                     state_d    = ST_HELD;
                  end else begin
                     match_cnt_d = CNT_W'(1);
                     state_d     = ST_DEBOUNCE;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (rows_s_q == pat_q) begin
                  if (match_cnt_q + CNT_W'(1) == DEB_TC) begin
                     accept      = 1'b1;
                     match_cnt_d = '0;
                     rel_cnt_d   = '0;
                     state_d     = ST_HELD;
                  end else begin
                     match_cnt_d = match_cnt_q + CNT_W'(1);
                  end
               end else begin
                  match_cnt_d = '0;
                  col_d       = col_q + 2'd1;
                  state_d     = ST_SCAN;
               end
            end
         end
         ST_HELD: begin
            if (tick) begin
               if (rows_s_q == 4'hF) begin
                  if (rel_cnt_q + CNT_W'(1) == DEB_TC) begin
                     rel_cnt_d = '0;
                     col_d     = col_q + 2'd1;
                     state_d   = ST_SCAN;
                  end else begin
                     rel_cnt_d = rel_cnt_q + CNT_W'(1);
                  end
               end else begin
                  rel_cnt_d = '0;
               end
            end
         end
         default: state_d = ST_SCAN;
      endcase

      // Accept takes priority over a same-cycle KEY_ACK.
      if (accept) begin
         key_code_d  = {4'h0, key_map(accept_row, col_q)};
         key_valid_d = 1'b1;
         intr_d      = 1'b1;
         overrun_d   = overrun_q | key_valid_q;
      end else if (KEY_ACK) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_SCAN;
         rows_meta_q <= 4'hF;
         rows_s_q    <= 4'hF;
         div_q       <= DIV_LOAD;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         pat_q       <= 4'hF;
         match_cnt_q <= '0;
         rel_cnt_q   <= '0;
         key_code_q  <= 8'h00;
         key_valid_q <= 1'b0;
         intr_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_meta_q <= rows_meta_d;
         rows_s_q    <= rows_s_d;
         div_q       <= div_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pat_q       <= pat_d;
         match_cnt_q <= match_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         intr_q      <= intr_d;
         overrun_q   <= overrun_d;
      end
   end

   assign COLS      = ~(4'b0001 << col_q);
   assign KEY_CODE  = key_code_q;
   assign KEY_VALID = key_valid_q;
   assign INTR      = intr_q;
   assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Keypad model drives ROWS from a set of pressed keys and the current COLS.
//   Each intended key press pushes its expected code and overrun flag into a
//   queue; a monitor pops and compares whenever INTR pulses.
module tb_keypad_scanner;

   logic       CLK;
   logic       RST;
   logic [3:0] ROWS;
   logic       KEY_ACK;
   logic [3:0] COLS;
   logic [7:0] KEY_CODE;
   logic       KEY_VALID;
   logic       INTR;
   logic       OVERRUN;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .CLK(CLK), .RST(RST), .ROWS(ROWS), .KEY_ACK(KEY_ACK), .COLS(COLS),
      .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .INTR(INTR), .OVERRUN(OVERRUN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Key legend, row-major, key (r,c) at nibble r*4+c.
   localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

   typedef struct packed {
      logic [3:0] code;
      logic       ovr;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          intr_count = 0;
   logic        intr_prev = 1'b0;
   logic [15:0] pressed;
   logic        model_valid;

   always_comb begin
      ROWS = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !COLS[c]) ROWS[r] = 1'b0;
   end

   function automatic logic [3:0] ref_code(input int r, input int c);
      logic [63:0] m;
      m = KEYMAP;
      return m[(r*4+c)*4 +: 4];
   endfunction

   function automatic logic [3:0] ref_cols(input int c);
      logic [3:0] m;
      m = 4'b0001 << c;
      return ~m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Monitor: every INTR must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!RST) begin
         check("cols_one_low", $countones(~COLS), 1);
         if (INTR) begin
            check("intr_single", {31'd0, intr_prev}, 0);
            intr_count++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL intr_unexpected code=%0h at %0t", KEY_CODE, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("intr_code", KEY_CODE, {4'h0, e.code});
               check("intr_valid", KEY_VALID, 1);
               check("intr_overrun", OVERRUN, e.ovr);
            end
         end
         intr_prev = INTR;
      end else begin
         intr_prev = 1'b0;
      end
   end

   task automatic expect_key(input int r, input int c);
      exp_t e;
      e.code = ref_code(r, c);
      e.ovr  = model_valid;
      exp_q.push_back(e);
      model_valid = 1'b1;
   endtask

   task automatic pulse_ack();
      KEY_ACK = 1'b1;
      step(1);
      KEY_ACK = 1'b0;
      model_valid = 1'b0;
      check("ack_valid", KEY_VALID, 0);
      check("ack_overrun", OVERRUN, 0);
   endtask

   task automatic press_release(input int r, input int c, input int hold, input int gap);
      int n0;
      expect_key(r, c);
      n0 = intr_count;
      pressed[r*4+c] = 1'b1;
      step(hold);
      check("press_one_intr", intr_count - n0, 1);
      check("held_cols", COLS, ref_cols(c));
      pressed = '0;
      step(gap);
   endtask

   task automatic wait_col_entry(input logic [3:0] target);
      logic [3:0] prev;
      int n;
      n = 0;
      prev = COLS;
      step(1);
      while (!(COLS == target && prev != target) && n < 40) begin
         prev = COLS;
         step(1);
         n++;
      end
      check("col_entry", COLS, target);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n;
      int n0;
      int changes;
      logic [3:0] prev;

      RST = 1'b1;
      KEY_ACK = 1'b0;
      pressed = '0;
      model_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset values and idle rotation, one column per 4 cycles.
      check("rst_code", KEY_CODE, 8'h00);
      check("rst_valid", KEY_VALID, 0);
      check("rst_intr", INTR, 0);
      check("rst_overrun", OVERRUN, 0);
      for (int k = 0; k < 64; k++) begin
         if (k % 4 == 0) check("idle_cols", COLS, ref_cols((k / 4) % 4));
         step(1);
      end
      check("idle_valid", KEY_VALID, 0);

      // Key 6: col2 arrives 8 cycles from now; accept 12 cycles after entry.
      expect_key(1, 2);
      n0 = intr_count;
      pressed[1*4+2] = 1'b1;
      n = 0;
      while (COLS != 4'b1011 && n < 20) begin
         step(1);
         n++;
      end
      check("k6_cols_entry", COLS, 4'b1011);
      step(11);
      check("k6_no_early_intr", INTR, 0);
      step(1);
      check("k6_intr", INTR, 1);
      check("k6_code", KEY_CODE, 8'h06);
      step(40);
      check("k6_one_intr", intr_count - n0, 1);
      check("k6_frozen", COLS, 4'b1011);
      pressed = '0;
      n = 0;
      while (COLS == 4'b1011 && n < 40) begin
         step(1);
         n++;
      end
      check("k6_resume_cols", COLS, 4'b0111);
      check("k6_release_latency", (n >= 11 && n <= 14), 1);
      pulse_ack();
      check("ack_code_hold", KEY_CODE, 8'h06);

      // Bounce on r0/c0: one matching tick then high, back to scanning.
      wait_col_entry(4'b1110);
      n0 = intr_count;
      pressed[0] = 1'b1;
      step(4);
      pressed = '0;
      n = 0;
      while (COLS == 4'b1110 && n < 20) begin
         step(1);
         n++;
      end
      check("bounce_next_col", COLS, 4'b1101);
      check("bounce_latency", n, 4);
      step(20);
      check("bounce_no_intr", intr_count - n0, 0);
      check("bounce_valid", KEY_VALID, model_valid);

      // Key 0 then # without ack: second accept flags overrun.
      press_release(3, 1, 50, 30);
      press_release(3, 2, 50, 30);
      check("ovr_flag", OVERRUN, 1);
      pulse_ack();
      check("ovr_code_hold", KEY_CODE, 8'h0F);

      // Two rows low on col3: no press, rotation continues.
      n0 = intr_count;
      pressed[0*4+3] = 1'b1;
      pressed[2*4+3] = 1'b1;
      changes = 0;
      for (int k = 0; k < 64; k++) begin
         prev = COLS;
         step(1);
         if (COLS != prev) changes++;
      end
      pressed = '0;
      check("multi_rotations", changes, 16);
      check("multi_no_intr", intr_count - n0, 0);
      step(20);

      // Randomized presses with occasional acks.
      for (int i = 0; i < 24; i++) begin
         int r, c;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         press_release(r, c, $urandom_range(40, 70), $urandom_range(24, 40));
         check("rand_valid", KEY_VALID, model_valid);
         if ($urandom_range(0, 1) == 1) pulse_ack();
      end

      // Reset while key D is held; re-detection needs a full scan.
      press_release(3, 3, 45, 0);
      pressed[15] = 1'b1;
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      model_valid = 1'b0;
      check("hrst_cols", COLS, 4'b1110);
      check("hrst_code", KEY_CODE, 8'h00);
      check("hrst_valid", KEY_VALID, 0);
      check("hrst_intr", INTR, 0);
      check("hrst_overrun", OVERRUN, 0);
      n0 = intr_count;
      step(20);
      check("hrst_no_early_intr", intr_count - n0, 0);
      expect_key(3, 3);
      step(20);
      check("hrst_redetect", intr_count - n0, 1);
      pressed = '0;
      step(30);

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
